// File: rtl/cylon_switch_conditioner_if.sv
// Switch-side bundle between the board switches and the cylon switch conditioner.
// Button lines exist only when CYLON_SPEED_BTN_EN is defined.
interface cylon_switch_conditioner_if;
  logic [5:0] sw_raw;
  logic [1:0] mode;
  logic [3:0] speed;
  logic       changed;
`ifdef CYLON_SPEED_BTN_EN
  logic       btn_up;
  logic       btn_dn;
`endif

  modport master (
    output sw_raw,
`ifdef CYLON_SPEED_BTN_EN
    output btn_up,
    output btn_dn,
`endif
    input  mode,
    input  speed,
    input  changed
  );

  modport slave (
    input  sw_raw,
`ifdef CYLON_SPEED_BTN_EN
    input  btn_up,
    input  btn_dn,
`endif
    output mode,
    output speed,
    output changed
  );
endinterface

// File: rtl/cylon_switch_conditioner.sv
// Synchronises and debounces the cylon slide switches into registered mode/speed plus a change strobe.
// Optional speed step buttons are enabled with `CYLON_SPEED_BTN_EN.
module cylon_switch_conditioner #(
  parameter int unsigned DEBOUNCE_CLKS = 1_000_000
) (
  input  logic                      clk,
  input  logic                      rst_n,
  cylon_switch_conditioner_if.slave sw_if
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CLKS);
  localparam logic [CNT_W-1:0] CNT_TC  = CNT_W'(DEBOUNCE_CLKS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

`ifdef CYLON_SPEED_BTN_EN
  localparam int NL = 8;
`else
  localparam int NL = 6;
`endif

  logic [NL-1:0]    raw;
  logic [NL-1:0]    s1_q, s1_d;
  logic [NL-1:0]    s2_q, s2_d;
  logic [NL-1:0]    stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q [NL];
  logic [CNT_W-1:0] cnt_d [NL];
  logic [1:0]       mode_q, mode_d;
  logic [3:0]       speed_q, speed_d;
  logic             changed_q, changed_d;

`ifdef CYLON_SPEED_BTN_EN
  logic [3:0] spd_q, spd_d;
  logic       up_evt, dn_evt;
  assign raw = {sw_if.btn_dn, sw_if.btn_up, sw_if.sw_raw};
`else
  assign raw = sw_if.sw_raw;
`endif

  // Per-lane debounce: a lane is accepted only after DEBOUNCE_CLKS consecutive disagreeing samples.
  always_comb begin
    s1_d     = raw;
    s2_d     = s1_q;
    stable_d = stable_q;
    for (int i = 0; i < NL; i++) begin
      cnt_d[i] = '0;
      if (s2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == CNT_TC) begin
          stable_d[i] = s2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_ONE;
        end
      end
    end
  end

`ifdef CYLON_SPEED_BTN_EN
  // Step register moves on the same edge stable does, so speed keeps the switch-path latency.
  always_comb begin
    up_evt = stable_d[6] & ~stable_q[6];
    dn_evt = stable_d[7] & ~stable_q[7];
    spd_d  = spd_q;
    if (|(stable_d[5:2] ^ stable_q[5:2])) begin
      spd_d = stable_d[5:2];
    end else if (up_evt && !dn_evt) begin
      spd_d = (spd_q == 4'hF) ? spd_q : spd_q + 4'd1;
    end else if (dn_evt && !up_evt) begin
      spd_d = (spd_q == 4'h0) ? spd_q : spd_q - 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spd_q <= '0;
    end else begin
      spd_q <= spd_d;
    end
  end
`endif

  always_comb begin
    mode_d = (stable_q[1:0] == 2'b11) ? 2'b00 : stable_q[1:0];
`ifdef CYLON_SPEED_BTN_EN
    speed_d = spd_q;
`else
    speed_d = stable_q[5:2];
`endif
    changed_d = ({mode_d, speed_d} != {mode_q, speed_q});
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q      <= '0;
      s2_q      <= '0;
      stable_q  <= '0;
      for (int i = 0; i < NL; i++) begin
        cnt_q[i] <= '0;
      end
      mode_q    <= '0;
      speed_q   <= '0;
      changed_q <= 1'b0;
    end else begin
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      stable_q  <= stable_d;
      for (int i = 0; i < NL; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      mode_q    <= mode_d;
      speed_q   <= speed_d;
      changed_q <= changed_d;
    end
  end

  assign sw_if.mode    = mode_q;
  assign sw_if.speed   = speed_q;
  assign sw_if.changed = changed_q;

endmodule

// File: tb/tb_cylon_switch_conditioner.sv
// Directed bench for cylon_switch_conditioner with DEBOUNCE_CLKS=8 (raw change to output = 11 edges).
// Button steps are exercised when CYLON_SPEED_BTN_EN is defined.
module tb_cylon_switch_conditioner;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;
  logic seen;

  cylon_switch_conditioner_if sw_if ();

  cylon_switch_conditioner #(.DEBOUNCE_CLKS(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sw_if (sw_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs are always driven 1 ns after an edge, so that edge is "edge 0".
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic watch_no_strobe(input int n);
    seen = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
      if (sw_if.changed !== 1'b0) seen = 1'b1;
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    sw_if.sw_raw = 6'h3F;
`ifdef CYLON_SPEED_BTN_EN
    sw_if.btn_up = 1'b0;
    sw_if.btn_dn = 1'b0;
`endif

    // 1: reset holds outputs at zero; release produces no strobe
    tick(4);
    chk("rst_mode", sw_if.mode, 0);
    chk("rst_speed", sw_if.speed, 0);
    chk("rst_changed", sw_if.changed, 0);
    rst_n = 1'b1;
    sw_if.sw_raw = 6'h00;
    watch_no_strobe(15);
    chk("rel_nostrobe", seen, 0);
    chk("rel_mode", sw_if.mode, 0);

    // 2: 0 -> 101010, accepted at exactly edge 11
    sw_if.sw_raw = 6'b101010;
    tick(10);
    chk("lat_e10_changed", sw_if.changed, 0);
    chk("lat_e10_mode", sw_if.mode, 0);
    tick(1);
    chk("lat_e11_mode", sw_if.mode, 2);
    chk("lat_e11_speed", sw_if.speed, 10);
    chk("lat_e11_changed", sw_if.changed, 1);
    tick(1);
    chk("lat_e12_changed", sw_if.changed, 0);
    chk("lat_e12_mode", sw_if.mode, 2);

    // 3: 5-clock glitch on bit 0 is rejected
    sw_if.sw_raw = 6'b101011;
    tick(5);
    sw_if.sw_raw = 6'b101010;
    watch_no_strobe(20);
    chk("glitch_nostrobe", seen, 0);
    chk("glitch_mode", sw_if.mode, 2);
    chk("glitch_speed", sw_if.speed, 10);

    // 4: mode 10 -> 01 (two lanes, one strobe), 01 -> 11 maps to 0, 11 -> 00 silent
    sw_if.sw_raw = 6'b101001;
    tick(11);
    chk("m01_mode", sw_if.mode, 1);
    chk("m01_changed", sw_if.changed, 1);
    tick(1);
    chk("m01_single", sw_if.changed, 0);
    tick(3);
    sw_if.sw_raw = 6'b101011;
    tick(11);
    chk("m11_mode", sw_if.mode, 0);
    chk("m11_changed", sw_if.changed, 1);
    tick(3);
    sw_if.sw_raw = 6'b101000;
    watch_no_strobe(15);
    chk("m11to00_nostrobe", seen, 0);
    chk("m00_mode", sw_if.mode, 0);

    // consecutive lane acceptances give separate strobes: speed 10 -> 11 -> 9
    sw_if.sw_raw = 6'b101100;
    tick(1);
    sw_if.sw_raw = 6'b100100;
    tick(10);
    chk("seq_e11_speed", sw_if.speed, 11);
    chk("seq_e11_changed", sw_if.changed, 1);
    tick(1);
    chk("seq_e12_speed", sw_if.speed, 9);
    chk("seq_e12_changed", sw_if.changed, 1);
    tick(1);
    chk("seq_e13_changed", sw_if.changed, 0);

    // 5: reset at count 5 of a pending change; held value re-accepted 11 edges after release
    sw_if.sw_raw = 6'b011101;
    tick(7);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_mode", sw_if.mode, 0);
    chk("mid_rst_speed", sw_if.speed, 0);
    tick(2);
    rst_n = 1'b1;
    tick(10);
    chk("post_rst_e10_changed", sw_if.changed, 0);
    chk("post_rst_e10_mode", sw_if.mode, 0);
    tick(1);
    chk("post_rst_e11_mode", sw_if.mode, 1);
    chk("post_rst_e11_speed", sw_if.speed, 7);
    chk("post_rst_e11_changed", sw_if.changed, 1);

`ifdef CYLON_SPEED_BTN_EN
    // 6: speed step buttons
    tick(2);
    sw_if.sw_raw = 6'b111001;
    tick(11);
    chk("btn_sw14", sw_if.speed, 14);
    sw_if.btn_up = 1'b1;
    tick(11);
    chk("btn_up1_speed", sw_if.speed, 15);
    chk("btn_up1_changed", sw_if.changed, 1);
    tick(5);
    chk("btn_held_once", sw_if.speed, 15);
    sw_if.btn_up = 1'b0;
    tick(12);
    sw_if.btn_up = 1'b1;
    watch_no_strobe(12);
    chk("btn_up2_sat", sw_if.speed, 15);
    chk("btn_up2_nostrobe", seen, 0);
    sw_if.btn_up = 1'b0;
    tick(12);
    sw_if.btn_up = 1'b1;
    sw_if.btn_dn = 1'b1;
    tick(12);
    chk("btn_both", sw_if.speed, 15);
    sw_if.btn_up = 1'b0;
    sw_if.btn_dn = 1'b0;
    tick(12);
    sw_if.btn_dn = 1'b1;
    tick(11);
    chk("btn_dn", sw_if.speed, 14);
    sw_if.btn_dn = 1'b0;
    tick(12);
    sw_if.sw_raw = 6'b001101;
    sw_if.btn_up = 1'b1;
    tick(11);
    chk("btn_sw_wins", sw_if.speed, 3);
    chk("btn_sw_wins_changed", sw_if.changed, 1);
    sw_if.btn_up = 1'b0;
    tick(12);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
